// File: rtl/gan_ctrl_pkg.sv
// Shared types and load-image layout for the GAN run controller.
// The optional watchdog is enabled by defining GAN_TIMEOUT_EN.
package gan_ctrl_pkg;

  localparam int N_X    = 4;
  localparam int N_W    = 54;
  localparam int N_B    = 19;
  localparam int X_BASE = 0;
  localparam int W_BASE = N_X;
  localparam int B_BASE = N_X + N_W;
  localparam int N_TOT  = N_X + N_W + N_B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/gan_res_buf.sv
// N_OUT-deep result capture buffer with a valid/ready drain port.
// Words are written in arrival order and drained in the same order.
module gan_res_buf #(
  parameter int WIDTH = 28,
  parameter int N_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cap_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             drain_en,
  input  logic             res_ready,
  output logic             cap_last,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_last,
  output logic             drain_done
);

  localparam int CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_OUT - 1);

  logic [CW-1:0]    wr_cnt;
  logic [CW-1:0]    rd_cnt;
  logic [WIDTH-1:0] mem [N_OUT];
  logic             cap_fire;

  assign cap_fire   = cap_en & in_valid;
  assign cap_last   = cap_fire && (wr_cnt == LAST);
  assign res_valid  = drain_en;
  assign res_last   = drain_en && (rd_cnt == LAST);
  assign res_data   = drain_en ? mem[rd_cnt] : '0;
  assign drain_done = res_valid & res_ready & res_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (clr) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (cap_fire)
        wr_cnt <= cap_last ? '0 : wr_cnt + CW'(1);
      if (res_valid && res_ready)
        rd_cnt <= res_last ? '0 : rd_cnt + CW'(1);
    end
  end

  // One register per slot so a discarded run leaves no stale words behind.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        mem[gi] <= '0;
      else if (clr)
        mem[gi] <= '0;
      else if (cap_fire && (wr_cnt == CW'(gi)))
        mem[gi] <= in_data;
    end
  end

endmodule

// File: rtl/gan_run_ctrl.sv
// Run controller: streams the parameter image into the GAN core, starts it,
// captures N_OUT results and drains them to the host. Watchdog: GAN_TIMEOUT_EN.
module gan_run_ctrl
  import gan_ctrl_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int ADDR_W      = 8,
  parameter int N_OUT       = 4,
  parameter int SETTLE      = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  output logic              run_busy,
  output logic              run_done,
  output logic              run_err,
  output logic              pmem_rd,
  output logic [ADDR_W-1:0] pmem_addr,
  input  logic [WIDTH-1:0]  pmem_rdata,
  output logic [ADDR_W-1:0] core_addr,
  output logic              core_we,
  output logic [WIDTH-1:0]  core_data,
  output logic              core_start,
  input  logic [WIDTH-1:0]  core_data_out,
  input  logic              core_data_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_last
);

  localparam int LD_W = $clog2(N_TOT + 1);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(N_TOT - 1);
  localparam logic [LD_W-1:0] LD_END  = LD_W'(N_TOT);
  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ST_W-1:0] ST_END = ST_W'(SETTLE - 1);

  state_t          state;
  logic [LD_W-1:0] ld_cnt;
  logic [ST_W-1:0] st_cnt;
  logic            rst_meta;
  logic            rst_n_s;
  logic            cap_last;
  logic            drain_done;
  logic            wd_expire;
  logic            buf_clr;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      {rst_n_s, rst_meta} <= 2'b00;
    else
      {rst_n_s, rst_meta} <= {rst_meta, 1'b1};
  end

  assign run_busy  = (state != ST_IDLE);
  assign run_done  = drain_done;
  assign core_data = core_we ? pmem_rdata : '0;
  assign buf_clr   = ((state == ST_IDLE) && run_req) || wd_expire;

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state      <= ST_IDLE;
      ld_cnt     <= '0;
      st_cnt     <= '0;
      pmem_rd    <= 1'b0;
      pmem_addr  <= '0;
      core_we    <= 1'b0;
      core_addr  <= '0;
      core_start <= 1'b0;
    end else begin
      // The core write trails the memory read by the one-cycle read latency.
      core_we    <= pmem_rd;
      core_addr  <= pmem_addr;
      core_start <= 1'b0;
      pmem_rd    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run_req) begin
            state     <= ST_LOAD;
            ld_cnt    <= '0;
            pmem_rd   <= 1'b1;
            pmem_addr <= '0;
          end
        end
        ST_LOAD: begin
          ld_cnt <= ld_cnt + LD_W'(1);
          if (ld_cnt < LD_LAST) begin
            pmem_rd   <= 1'b1;
            pmem_addr <= ADDR_W'(ld_cnt + LD_W'(1));
          end else begin
            pmem_addr <= '0;
          end
          if (ld_cnt == LD_END) begin
            state  <= ST_SETTLE;
            st_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (st_cnt == ST_END) begin
            state      <= ST_START;
            core_start <= 1'b1;
          end else begin
            st_cnt <= st_cnt + ST_W'(1);
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (cap_last)
            state <= ST_DRAIN;
          else if (wd_expire)
            state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (drain_done)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GAN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // wd_cnt equals the number of cycles since the start pulse while waiting.
  assign wd_expire = (state == ST_WAIT) && (wd_cnt == WD_END) && !cap_last;
  assign run_err   = err_q;

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wd_expire;
      if (state == ST_START)
        wd_cnt <= WD_W'(1);
      else if (state == ST_WAIT)
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_expire = 1'b0;
  assign run_err   = 1'b0;
`endif

  gan_res_buf #(
    .WIDTH (WIDTH),
    .N_OUT (N_OUT)
  ) u_res_buf (
    .clk        (clk),
    .rst_n      (rst_n_s),
    .clr        (buf_clr),
    .cap_en     (state == ST_WAIT),
    .in_valid   (core_data_valid),
    .in_data    (core_data_out),
    .drain_en   (state == ST_DRAIN),
    .res_ready  (res_ready),
    .cap_last   (cap_last),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_last   (res_last),
    .drain_done (drain_done)
  );

endmodule

// File: tb/tb_gan_run_ctrl.sv
// Scoreboard bench for gan_run_ctrl; define GAN_TIMEOUT_EN to exercise the watchdog.
module tb_gan_run_ctrl;
  import gan_ctrl_pkg::*;

  localparam int WIDTH  = 28;
  localparam int ADDR_W = 8;
  localparam int N_OUT  = 4;
  localparam int SETTLE = 2;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run_req = 1'b0;
  logic              run_busy, run_done, run_err;
  logic              pmem_rd;
  logic [ADDR_W-1:0] pmem_addr;
  logic [WIDTH-1:0]  pmem_rdata = '0;
  logic [ADDR_W-1:0] core_addr;
  logic              core_we;
  logic [WIDTH-1:0]  core_data;
  logic              core_start;
  logic [WIDTH-1:0]  core_data_out = '0;
  logic              core_data_valid = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [WIDTH-1:0]  res_data;
  logic              res_last;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  longint wq_addr[$];
  longint wq_data[$];
  longint rq[$];

  gan_run_ctrl #(
    .WIDTH       (WIDTH),
    .ADDR_W      (ADDR_W),
    .N_OUT       (N_OUT),
    .SETTLE      (SETTLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .run_req         (run_req),
    .run_busy        (run_busy),
    .run_done        (run_done),
    .run_err         (run_err),
    .pmem_rd         (pmem_rd),
    .pmem_addr       (pmem_addr),
    .pmem_rdata      (pmem_rdata),
    .core_addr       (core_addr),
    .core_we         (core_we),
    .core_data       (core_data),
    .core_start      (core_start),
    .core_data_out   (core_data_out),
    .core_data_valid (core_data_valid),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_last        (res_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Synchronous parameter memory holding pmem[a] = 3a - 100.
  always @(posedge clk)
    if (pmem_rd) pmem_rdata <= WIDTH'(3 * int'(pmem_addr) - 100);

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: core writes and result handshakes against the scoreboard.
  int     we_run = 0;
  int     last_we_cyc = 0;
  bit     prev_we = 1'b0;
  bit     done_prev = 1'b0;
  longint e_val;

  always @(negedge clk) begin
    if (!rst) begin
      prev_we = 1'b0;
      we_run = 0;
      done_prev = 1'b0;
      wq_addr.delete();
      wq_data.delete();
    end else begin
      if (core_we) begin
        we_run++;
        last_we_cyc = cyc;
        if (wq_addr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_addr", core_addr, wq_addr.pop_front());
          check("wr_data", $signed(core_data), wq_data.pop_front());
        end
      end else if (prev_we) begin
        check("we_run_len", we_run, N_TOT);
        $display("load: %0d consecutive core writes", we_run);
        we_run = 0;
      end
      prev_we = core_we;
      if (core_start) check("start_gap", cyc - last_we_cyc, SETTLE + 1);
      if (done_prev) check("busy_after_done", run_busy, 0);
      done_prev = run_done;
      if (run_done && !(res_valid && res_ready)) check("done_spurious", 1, 0);
      if (res_valid && res_ready) begin
        if (rq.size() == 0) check("res_unexpected", 1, 0);
        else begin
          e_val = rq.pop_front();
          $display("result: data=%0d last=%0d done=%0d", $signed(res_data), res_last, run_done);
          check("res_data", $signed(res_data), e_val);
          check("res_last", res_last, (rq.size() == 0) ? 1 : 0);
          check("run_done", run_done, (rq.size() == 0) ? 1 : 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    for (int a = 0; a < N_TOT; a++) begin
      wq_addr.push_back(a);
      wq_data.push_back(3 * a - 100);
    end
    run_req = 1'b1;
    idle(1);
    run_req = 1'b0;
  endtask

  task automatic wait_start(output int c);
    bit seen = 1'b0;
    c = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (core_start) begin
        seen = 1'b1;
        c = cyc;
      end
    end
    if (!seen) check("start_timeout", 0, 1);
    idle(1);
  endtask

  task automatic feed(input longint v);
    core_data_valid = 1'b1;
    core_data_out = WIDTH'(v);
    rq.push_back(v);
    idle(1);
    core_data_valid = 1'b0;
    core_data_out = '0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!run_busy) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 0, 1);
    check("rq_drained", rq.size(), 0);
    idle(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {run_busy, run_done, run_err, pmem_rd, pmem_addr, core_we,
                           core_addr, core_start, res_valid, res_last}, 0);
    check({tag, "_data"}, {core_data, res_data}, 0);
  endtask

  initial begin
    #20000000;
    $display("FAIL sim_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s;
    bit found;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    idle(1);
    rst = 1'b1;
    idle(4);
    check("idle_busy", run_busy, 0);

    // Basic load, start and capture with an always-ready sink.
    $display("run: basic");
    res_ready = 1'b1;
    pulse_run();
    wait_start(s);
    feed(11); feed(-22); feed(33); feed(-44);
    wait_idle();

    // Backpressure at the start of the drain.
    $display("run: backpressure");
    res_ready = 1'b0;
    pulse_run();
    wait_start(s);
    feed(11); feed(-22); feed(33); feed(-44);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", res_valid, 1);
      check("bp_data", $signed(res_data), 11);
    end
    idle(1);
    res_ready = 1'b1;
    wait_idle();

    // Stray valid and run_req during LOAD, then gapped results.
    $display("run: gapped valid");
    pulse_run();
    idle(3);
    core_data_valid = 1'b1;
    core_data_out = WIDTH'(999);
    idle(1);
    core_data_valid = 1'b0;
    core_data_out = '0;
    run_req = 1'b1;
    idle(1);
    run_req = 1'b0;
    wait_start(s);
    feed(5); feed(6);
    idle(3);
    feed(7); feed(8);
    wait_idle();

    // Reset while loading word 30, then a clean rerun.
    $display("run: reset mid-load");
    pulse_run();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (core_we && core_addr == ADDR_W'(30)) found = 1'b1;
    end
    if (!found) check("addr30_timeout", 0, 1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    idle(3);
    rst = 1'b1;
    idle(4);
    check("idle_after_reset", run_busy, 0);
    pulse_run();
    wait_start(s);
    feed(1); feed(-2); feed(3); feed(-4);
    wait_idle();

    // Core never answers.
    $display("run: no core response");
    pulse_run();
    wait_start(s);
`ifdef GAN_TIMEOUT_EN
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (run_err) begin
        found = 1'b1;
        check("err_delay", cyc - s, TMO);
        check("err_busy", run_busy, 0);
        check("err_res_valid", res_valid, 0);
      end
    end
    if (!found) check("err_timeout", 0, 1);
    idle(2);
    check("err_pulse_len", run_err, 0);
`else
    idle(TMO + 20);
    check("wait_busy", run_busy, 1);
    check("wait_err", run_err, 0);
    check("wait_res_valid", res_valid, 0);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gan_run_ctrl.md
Name: gan_run_ctrl

Overview:
Run controller for the hardware-shared GAN core.
- Streams the full parameter image (x, w, b) from a synchronous parameter memory into the core's addr/we/data_in load port.
- Pulses the core's start, captures the N_OUT result words that the core qualifies with data_valid, and drains them to a host over a valid/ready stream.
- Sits between the host/parameter memory and the GAN core, replacing hand-driven load sequences.

Parameters:
WIDTH, 28, signed data word width (matches core)
ADDR_W, 8, core and parameter-memory address width
N_X, 4, input words, core addresses 0..N_X-1
N_W, 54, weight words, core addresses N_X..N_X+N_W-1
N_B, 19, bias words, following the weights
N_OUT, 4, result words per run
SETTLE, 2, idle cycles between last core write and start pulse
TIMEOUT_CYC, 1024, watchdog limit (only with GAN_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
run_req  in  1  start a run; sampled only in IDLE
run_busy  out  1  high in every state except IDLE
run_done  out  1  1-cycle pulse on last result handshake
run_err  out  1  1-cycle pulse on watchdog expiry; constant 0 without macro
pmem_rd  out  1  parameter memory read strobe
pmem_addr  out  ADDR_W  parameter memory address
pmem_rdata  in  WIDTH  read data, valid the cycle after pmem_rd
core_addr  out  ADDR_W  core load address
core_we  out  1  core load write enable
core_data  out  WIDTH  core load data
core_start  out  1  core start, 1-cycle pulse
core_data_out  in  WIDTH  core result word
core_data_valid  in  1  core result qualifier
res_valid  out  1  result stream valid
res_ready  in  1  result stream ready
res_data  out  WIDTH  result word
res_last  out  1  high with the N_OUT-th word

Behaviour:
Reset and run acceptance
- rst low: all outputs 0, state IDLE, counters and buffer cleared. Asynchronous assert, synchronous release.
- Reset mid-run aborts with no done/err pulse. The next run restarts at address 0.
- IDLE: run_req high -> LOAD. run_req in any other state is ignored.

Load and start
- N_TOT = N_X+N_W+N_B (77).
- LOAD cycle k (0..N_TOT-1): pmem_rd=1, pmem_addr=k.
- Cycle k+1: core_we=1, core_addr=k, core_data=pmem_rdata.
- Result: N_TOT consecutive core_we cycles, one cycle behind the reads. LOAD lasts N_TOT+1 cycles.
- SETTLE: SETTLE cycles with core_we=0 -> START.
- START: core_start=1 for exactly one cycle -> WAIT.

Capture
- WAIT/CAPTURE: each cycle with core_data_valid=1 stores core_data_out at buffer[cnt], then cnt++.
- Gaps in valid are allowed. cnt==N_OUT -> DRAIN.
- core_data_valid is ignored in all other states.

Drain
- res_valid=1, res_data=buffer[rd].
- res_data and res_last are held stable while res_ready=0.
- Handshake (valid&ready) advances rd.
- Last handshake: run_done pulse -> IDLE.
- res_last is high only when rd==N_OUT-1.

Arithmetic
- Data is passed through unmodified; no arithmetic on data. Counters are sized by clog2.

Optional Feature:
GAN_TIMEOUT_EN
- Defined: a watchdog counter starts at core_start. If it reaches TIMEOUT_CYC before N_OUT words are captured: run_err pulse, buffer discarded, -> IDLE, res_valid never asserted.
- Undefined: WAIT is unbounded, run_err is tied 0, and the counter is not built.

Decomposition:
- Package gan_ctrl_pkg holds:
  - state enum (IDLE, LOAD, SETTLE, START, WAIT, DRAIN)
  - base constants X_BASE=0, W_BASE=N_X, B_BASE=N_X+N_W
  - N_TOT
- One sub-module, gan_res_buf: N_OUT-deep capture buffer with write counter and valid/ready drain logic (res_valid/res_data/res_last).

Test Plan:
- Load: pmem[a]=3a-100, run_req 1 cycle -> core_we high 77 consecutive cycles, core_addr 0..76, core_data 3a-100; core_start single pulse SETTLE+1 cycles after last write.
- Capture: core valid 4 consecutive cycles with 11,-22,33,-44, res_ready=1 -> res_data 11,-22,33,-44; res_last on -44; run_done pulse same cycle as last handshake; run_busy low next cycle.
- Backpressure: res_ready low 5 cycles at start of DRAIN -> res_valid=1, res_data=11 stable; sequence intact after ready rises.
- Gapped valid: valid 2 cycles (5,6), gap 3, 2 cycles (7,8) -> outputs 5,6,7,8; a valid pulse during LOAD is ignored.
- Reset mid-load at word 30 -> all outputs 0 immediately; new run_req reloads from addr 0 with 77 writes.
- GAN_TIMEOUT_EN with TIMEOUT_CYC=64, core never valid -> run_err pulse 64 cycles after core_start, then IDLE, no res_valid; without macro the controller stays in WAIT.
